fetch_unit: RTL and testbench

//   Owns the architectural fetch PC and drives instruction memory. Consumes the

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 35 +++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc,inst} buffer with flush and occupancy count
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, sequential prefetch and decode handoff buffer.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, discard, count;
  fetch_entry_t head;
  logic fire, rv, keep, push, pop, empty, byp;
  assign empty = count == '0;
  // credit uses registered counts only, so a same-cycle pop never frees a slot early
  assign imem_req = !rst && !redirect && (int'(outstanding) + int'(count) < FIFO_DEPTH);
  assign imem_addr = fetch_pc;
  assign fire = imem_req && imem_gnt;
  assign rv = imem_rvalid && outstanding != '0;
  assign keep = rv && discard == '0 && !redirect;
`ifdef FETCH_BYPASS_EN
  assign byp = keep && empty;
`else
  assign byp = 1'b0;
`endif
  assign push = keep && !(byp && inst_ready);
  assign pop = !empty && inst_ready;
  assign inst_valid = !rst && (!empty || byp);
  always_comb begin
    inst = !inst_valid ? '0 : empty ? imem_rdata : head.inst;
    inst_pc = !inst_valid ? '0 : empty ? resp_pc : head.pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(rv);
      if (redirect) begin
        fetch_pc <= redirect_pc & INST_ALIGN_MASK;
        resp_pc <= redirect_pc & INST_ALIGN_MASK;
        discard <= outstanding - CW'(rv);
      end else begin
        if (fire) fetch_pc <= fetch_pc + PC_STEP;
        if (keep) resp_pc <= resp_pc + PC_STEP;
        if (rv && discard != '0) discard <= discard - 1'b1;
      end
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .push(push),
    .wdata('{pc: resp_pc, inst: imem_rdata}),
    .pop(pop),
    .rdata(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a zero-wait in-order memory model
module tb_fetch_unit;
  logic clk, rst, redirect, imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, inst_pc;
  logic rsp_en;
  logic [31:0] q[$];
  logic [31:0] ea, ep;
  int n_cmp, n_err, ng, np;
  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // one clock; the memory grants in-order and answers the cycle after the grant
  task automatic tick();
    logic g;
    logic [31:0] a, d;
    g = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    if (imem_rvalid) d = q.pop_front();
    if (g) q.push_back(a);
    if (rst) q.delete();
    #1;
    imem_rvalid = rsp_en && q.size() > 0;
    imem_rdata = imem_rvalid ? mem(q[0]) : 32'h0;
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (imem_req && imem_gnt) begin
        chk("grant_addr", imem_addr, ea);
        ea += 32'd4;
        ng++;
      end
      if (inst_valid && inst_ready) begin
        chk("inst_pc", inst_pc, ep);
        chk("inst_word", inst, mem(ep));
        ep += 32'd4;
        np++;
      end
      tick();
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask
  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b1; rsp_en = 1'b1;
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    rst = 1'b0;
    #1;
    chk("t1_first_addr", imem_addr, 32'h0);
    ea = 0; ep = 0; ng = 0; np = 0;
    run(24);
    chk("t1_pops", np >= 6, 1);
    // buffer fills with decode stalled
    do_reset();
    inst_ready = 1'b0;
    ea = 0; ep = 0; ng = 0; np = 0;
    run(8);
    chk("t2_grants", ng, 2);
    chk("t2_req_off", imem_req, 0);
    chk("t2_valid", inst_valid, 1);
    chk("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    ng = 0; np = 0;
    run(16);
    chk("t2_resumed", ng >= 2 && np >= 4, 1);
    // redirect with two requests in flight
    do_reset();
    rsp_en = 1'b0;
    chk("t3_addr0", imem_addr, 32'h0);
    tick();
    chk("t3_addr4", imem_addr, 32'h4);
    tick();
    chk("t3_capped", imem_req, 0);
    redirect = 1'b1; redirect_pc = 32'h100; rsp_en = 1'b1;
    #1;
    chk("t3_redir_req", imem_req, 0);
    tick();
    redirect = 1'b0;
    #1;
    ea = 32'h100; ep = 32'h100; ng = 0; np = 0;
    run(12);
    chk("t3_progress", ng >= 2 && np >= 2, 1);
    // redirect in the same cycle as the only response
    do_reset();
    rsp_en = 1'b0;
    chk("t4_addr0", imem_addr, 32'h0);
    tick();
    imem_gnt = 1'b0; rsp_en = 1'b1;
    tick();
    chk("t4_rvalid", imem_rvalid, 1);
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    tick();
    redirect = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("t4_no_stale", inst_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    ea = 32'h200; ep = 32'h200; ng = 0; np = 0;
    run(10);
    chk("t4_progress", np >= 2, 1);
    // address wrap and misaligned redirect target
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    ea = 32'hFFFF_FFFC; ep = 32'hFFFF_FFFC; ng = 0; np = 0;
    run(10);
    chk("t5_wrapped", ng >= 3 && np >= 2, 1);
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    chk("t5_redir_req", imem_req, 0);
    tick();
    redirect = 1'b0;
    #1;
    ea = 32'h100; ep = 32'h100; ng = 0; np = 0;
    run(12);
    chk("t5_aligned", ng >= 2 && np >= 2, 1);
    // reset mid-operation drops buffered and in-flight words
    do_reset();
    inst_ready = 1'b0;
    tick();
    tick();
    chk("t6_buffered", inst_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", inst_valid, 0);
    chk("t6_rst_inst", inst, 0);
    tick();
    chk("t6_after_valid", inst_valid, 0);
    chk("t6_after_req", imem_req, 0);
    rst = 1'b0; inst_ready = 1'b1;
    #1;
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 32'h0);
    ea = 0; ep = 0; ng = 0; np = 0;
    run(10);
    chk("t6_progress", np >= 2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
